// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port, one-cycle-latency RAM.
// Registers the winning command onto the RAM port and steers read data back by owner tag.
module ram_port_arbiter #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int ADDRESS_WIDTH    = 32,
  parameter int MAX_BURST        = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          r0_req,
  input  logic [MEMORY_BUS_WIDTH/8-1:0] r0_wb,
  input  logic [ADDRESS_WIDTH-1:0]      r0_addr,
  input  logic [MEMORY_BUS_WIDTH-1:0]   r0_wdata,
  output logic                          r0_gnt,
  output logic                          r0_rvalid,
  output logic [MEMORY_BUS_WIDTH-1:0]   r0_rdata,
  input  logic                          r1_req,
  input  logic [MEMORY_BUS_WIDTH/8-1:0] r1_wb,
  input  logic [ADDRESS_WIDTH-1:0]      r1_addr,
  input  logic [MEMORY_BUS_WIDTH-1:0]   r1_wdata,
  output logic                          r1_gnt,
  output logic                          r1_rvalid,
  output logic [MEMORY_BUS_WIDTH-1:0]   r1_rdata,
  output logic                          mem_enable,
  output logic [MEMORY_BUS_WIDTH/8-1:0] mem_wb,
  output logic [ADDRESS_WIDTH-1:0]      mem_addr,
  output logic [MEMORY_BUS_WIDTH-1:0]   mem_wdata,
  input  logic [MEMORY_BUS_WIDTH-1:0]   mem_rdata
);
  localparam int WB_W  = MEMORY_BUS_WIDTH / 8;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef struct packed {
    logic [WB_W-1:0]             wb;
    logic [ADDRESS_WIDTH-1:0]    addr;
    logic [MEMORY_BUS_WIDTH-1:0] wdata;
  } cmd_t;

  typedef enum logic { PRIO0 = 1'b0, PRIO1 = 1'b1 } prio_t;

  prio_t            prio, prio_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic [1:0]       req, gnt;
  cmd_t [1:0]       cmd;
  cmd_t             win;
  logic             accept, win_id, p, op;
  logic [1:0]       vld_pipe, id_pipe;

  assign req    = {r1_req, r0_req};
  assign cmd[0] = {r0_wb, r0_addr, r0_wdata};
  assign cmd[1] = {r1_wb, r1_addr, r1_wdata};
  assign p      = (prio == PRIO1);
  assign op     = ~p;

  always_comb begin
    gnt = '0;
    if (req[p])       gnt[p]  = 1'b1;
    else if (req[op]) gnt[op] = 1'b1;
  end

  assign accept = |gnt;
  assign win_id = gnt[1];
  assign win    = cmd[win_id];
  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];

  // Only accepts made while the other side is waiting count toward the burst limit.
  always_comb begin
    prio_nxt      = prio;
    burst_cnt_nxt = burst_cnt;
    if (accept) begin
      if (win_id == p) begin
        if (req[op]) begin
          if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
            prio_nxt      = prio_t'(op);
            burst_cnt_nxt = '0;
          end else begin
            burst_cnt_nxt = burst_cnt + 1'b1;
          end
        end
      end else begin
        prio_nxt      = prio_t'(op);
        burst_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prio      <= PRIO0;
      burst_cnt <= '0;
    end else begin
      prio      <= prio_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_enable <= 1'b0;
      mem_wb     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_enable <= accept;
      mem_wb     <= accept ? win.wb : '0;
      if (accept) begin
        mem_addr  <= win.addr;
        mem_wdata <= win.wdata;
      end
    end
  end

  // Stage 0 tracks the command on the RAM port; stage 1 lines up with mem_rdata.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], accept & ~|win.wb};
      id_pipe  <= {id_pipe[0], win_id};
    end
  end

  assign r0_rvalid = vld_pipe[1] & ~id_pipe[1];
  assign r1_rvalid = vld_pipe[1] &  id_pipe[1];
  assign r0_rdata  = mem_rdata;
  assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: per-cycle vector table plus burst and reset sequences.
module tb_ram_port_arbiter;
  localparam logic [31:0] A0 = 32'h100, A1 = 32'h104, AW = 32'h200;
  localparam logic [31:0] D0 = 32'hDEADBEEF, D1 = 32'h12345678;

  logic        clock, reset;
  logic        r0_req, r1_req, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_enable;
  logic [3:0]  r0_wb, r1_wb, mem_wb;
  logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata, r0_rdata, r1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram [0:255];

  int n_vec = 0;
  int n_err = 0;

  ram_port_arbiter #(.MEMORY_BUS_WIDTH(32), .ADDRESS_WIDTH(32), .MAX_BURST(4)) dut (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_wb(r0_wb), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_wb(r1_wb), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_enable(mem_enable), .mem_wb(mem_wb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // RAM model: registered read, byte strobe bit0 selects bits [31:24].
  always @(posedge clock) begin
    if (mem_enable) begin
      if (mem_wb == 4'h0) mem_rdata <= ram[mem_addr[9:2]];
      else
        for (int b = 0; b < 4; b++)
          if (mem_wb[b]) ram[mem_addr[9:2]][31-8*b -: 8] <= mem_wdata[31-8*b -: 8];
    end
  end

  typedef struct {
    logic [1:0]  q;
    logic [3:0]  wb0, wb1;
    logic [31:0] a0, d0, a1, d1;
    logic [1:0]  g, rv;
    logic [31:0] rd;
    logic        me;
    logic [31:0] ma;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [1:0] q, input logic [3:0] wb0, input logic [31:0] a0, d0,
                              input logic [3:0] wb1, input logic [31:0] a1, d1,
                              input logic [1:0] g, rv, input logic [31:0] rd,
                              input logic me, input logic [31:0] ma);
    vec_t v;
    v.q = q; v.wb0 = wb0; v.a0 = a0; v.d0 = d0; v.wb1 = wb1; v.a1 = a1; v.d1 = d1;
    v.g = g; v.rv = rv; v.rd = rd; v.me = me; v.ma = ma;
    return v;
  endfunction

  function automatic vec_t rr(input logic [1:0] q, g, rv, input logic [31:0] rd,
                              input logic me, input logic [31:0] ma);
    return mk(q, 4'h0, A0, 32'h0, 4'h0, A1, 32'h0, g, rv, rd, me, ma);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    r0_req = v.q[0]; r0_wb = v.wb0; r0_addr = v.a0; r0_wdata = v.d0;
    r1_req = v.q[1]; r1_wb = v.wb1; r1_addr = v.a1; r1_wdata = v.d1;
  endtask

  task automatic idle_inputs();
    r0_req = 0; r0_wb = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_wb = 0; r1_addr = 0; r1_wdata = 0;
  endtask

  initial begin
    int n0;
    bit got1;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[A0[9:2]] = D0;
    ram[A1[9:2]] = D1;
    mem_rdata = 32'h0;
    idle_inputs();
    reset = 1'b0;

    // single read, then contention 0,0,0,0,1,1,1,1,0
    vq.push_back(rr(2'b01, 2'b01, 2'b00, 0,  0, 0));   // 0
    vq.push_back(rr(2'b00, 2'b00, 2'b00, 0,  1, A0));
    vq.push_back(rr(2'b00, 2'b00, 2'b01, D0, 0, 0));
    vq.push_back(rr(2'b00, 2'b00, 2'b00, 0,  0, 0));
    vq.push_back(rr(2'b11, 2'b01, 2'b00, 0,  0, 0));   // 4
    vq.push_back(rr(2'b11, 2'b01, 2'b00, 0,  1, A0));
    vq.push_back(rr(2'b11, 2'b01, 2'b01, D0, 1, A0));
    vq.push_back(rr(2'b11, 2'b01, 2'b01, D0, 1, A0));
    vq.push_back(rr(2'b11, 2'b10, 2'b01, D0, 1, A0));  // 8
    vq.push_back(rr(2'b11, 2'b10, 2'b01, D0, 1, A1));
    vq.push_back(rr(2'b11, 2'b10, 2'b10, D1, 1, A1));
    vq.push_back(rr(2'b11, 2'b10, 2'b10, D1, 1, A1));
    vq.push_back(rr(2'b11, 2'b01, 2'b10, D1, 1, A1));  // 12
    // five idle cycles: burst count 1 must survive
    vq.push_back(rr(2'b00, 2'b00, 2'b10, D1, 1, A0));
    vq.push_back(rr(2'b00, 2'b00, 2'b01, D0, 0, 0));
    vq.push_back(rr(2'b00, 2'b00, 2'b00, 0,  0, 0));
    vq.push_back(rr(2'b00, 2'b00, 2'b00, 0,  0, 0));
    vq.push_back(rr(2'b00, 2'b00, 2'b00, 0,  0, 0));
    vq.push_back(rr(2'b11, 2'b01, 2'b00, 0,  0, 0));   // 18
    vq.push_back(rr(2'b11, 2'b01, 2'b00, 0,  1, A0));
    vq.push_back(rr(2'b11, 2'b01, 2'b01, D0, 1, A0));
    vq.push_back(rr(2'b11, 2'b10, 2'b01, D0, 1, A0));
    vq.push_back(rr(2'b00, 2'b00, 2'b01, D0, 1, A1));
    vq.push_back(rr(2'b00, 2'b00, 2'b10, D1, 0, 0));
    vq.push_back(rr(2'b00, 2'b00, 2'b00, 0,  0, 0));
    // write by r0, read-back by r1, then a single-byte write
    vq.push_back(mk(2'b01, 4'hF, AW, 32'hCAFEBABE, 4'h0, AW, 0, 2'b01, 2'b00, 0, 0, 0));  // 25
    vq.push_back(mk(2'b10, 4'h0, AW, 0, 4'h0, AW, 0, 2'b10, 2'b00, 0, 1, AW));
    vq.push_back(mk(2'b01, 4'h1, AW, 32'h11000000, 4'h0, AW, 0, 2'b01, 2'b00, 0, 1, AW));
    vq.push_back(mk(2'b10, 4'h0, AW, 0, 4'h0, AW, 0, 2'b10, 2'b10, 32'hCAFEBABE, 1, AW));
    vq.push_back(rr(2'b00, 2'b00, 2'b00, 0, 1, AW));
    vq.push_back(rr(2'b00, 2'b00, 2'b10, 32'h11FEBABE, 0, 0));
    vq.push_back(rr(2'b00, 2'b00, 2'b00, 0, 0, 0));

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst mem_enable", {31'd0, mem_enable}, 32'd0);
    chk("rst mem_wb", {28'd0, mem_wb}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst rvalid", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(negedge clock);
      chk($sformatf("row%0d gnt", i), {30'd0, r1_gnt, r0_gnt}, {30'd0, vq[i].g});
      chk($sformatf("row%0d rvalid", i), {30'd0, r1_rvalid, r0_rvalid}, {30'd0, vq[i].rv});
      if (vq[i].rv[0]) chk($sformatf("row%0d r0_rdata", i), r0_rdata, vq[i].rd);
      if (vq[i].rv[1]) chk($sformatf("row%0d r1_rdata", i), r1_rdata, vq[i].rd);
      chk($sformatf("row%0d mem_enable", i), {31'd0, mem_enable}, {31'd0, vq[i].me});
      if (vq[i].me) chk($sformatf("row%0d mem_addr", i), mem_addr, vq[i].ma);
      else          chk($sformatf("row%0d mem_wb", i), {28'd0, mem_wb}, 32'd0);
      @(posedge clock); #1;
    end

    // uncontended burst of 10, then contention: r0 gets exactly 4 more
    drive(rr(2'b01, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk($sformatf("solo%0d gnt", i), {30'd0, r1_gnt, r0_gnt}, 32'd1);
      @(posedge clock); #1;
    end
    drive(rr(2'b11, 0, 0, 0, 0, 0));
    n0 = 0;
    got1 = 0;
    for (int i = 0; i < 12 && !got1; i++) begin
      @(negedge clock);
      if (r0_gnt && r1_gnt) chk("burst both gnt", 32'd1, 32'd0);
      if (r1_gnt) got1 = 1;
      else if (r0_gnt) n0++;
      @(posedge clock); #1;
    end
    chk("burst r1 granted", {31'd0, got1}, 32'd1);
    chk("burst r0 count", n0, 32'd4);
    idle_inputs();
    repeat (4) @(posedge clock);
    #1;

    // reset while an r1 read is in flight (priority currently with r1)
    drive(rr(2'b10, 0, 0, 0, 0, 0));
    @(negedge clock);
    chk("mid r1 gnt", {30'd0, r1_gnt, r0_gnt}, 32'd2);
    @(posedge clock); #1;
    idle_inputs();
    chk("mid pre mem_enable", {31'd0, mem_enable}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid rst mem_enable", {31'd0, mem_enable}, 32'd0);
    chk("mid rst rvalid", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("post rst rvalid%0d", i), {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
    end
    @(posedge clock); #1;
    drive(rr(2'b11, 0, 0, 0, 0, 0));
    @(negedge clock);
    chk("post rst gnt", {30'd0, r1_gnt, r0_gnt}, 32'd1);
    @(posedge clock); #1;
    idle_inputs();
    repeat (3) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
